// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared memory-op encodings and the dmem controller state type.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Memory operation encodings, shared with the decoder and execute stage.
    localparam int                     MEM_OP_BITS  = 2;
    localparam logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'd1;
    localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'd2;

    // Controller states: CLEAR sweeps zeros into the array, RUN serves requests.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH x DATA_WIDTH storage, one byte-enabled write port and
//               one registered read port. No reset; contents are zeroed by
//               the controller's clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_re,
    input  logic [IDX_W-1:0]        i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int c_lanes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Byte-lane write: only lanes with their strobe bit set are updated.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read; the output holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_sync.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sync
// Description : MEM-stage data memory with valid/ready requests, byte
//               strobes, one-cycle registered responses, out-of-range error
//               and a post-reset clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [MEM_OP_BITS-1:0]  mem_op,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cmp_w = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DEPTH - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_idx_w-1:0]      r_clr_idx;
    logic                    r_rd_sel;

    logic                    w_in_range;
    logic                    w_is_rw;
    logic                    w_accept;
    logic                    w_we;
    logic                    w_re;
    logic [c_idx_w-1:0]      w_waddr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH/8-1:0] w_wstrb;
    logic [DATA_WIDTH-1:0]   w_arr_rdata;

    assign w_in_range = c_cmp_w'(address) < c_cmp_w'(DEPTH);
    assign w_is_rw    = (mem_op == MEM_OP_READ) || (mem_op == MEM_OP_WRITE);

    // State register and clear-sweep index; reset restarts the sweep at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) begin
                r_clr_idx <= (r_clr_idx == c_last_idx) ? '0 : r_clr_idx + c_idx_w'(1);
            end
        end
    end

    // Next state, handshake outputs and array port steering.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_waddr      = address[c_idx_w-1:0];
        w_wdata      = write_data;
        w_wstrb      = write_strb;
        case (r_state)
            CLEAR: begin
                busy    = 1'b1;
                w_we    = 1'b1;
                w_waddr = r_clr_idx;
                w_wdata = '0;
                w_wstrb = '1;
                if (r_clr_idx == c_last_idx) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                req_ready = 1'b1;
                w_accept  = req_valid && w_is_rw;
                w_we      = w_accept && (mem_op == MEM_OP_WRITE) && w_in_range;
                w_re      = w_accept && (mem_op == MEM_OP_READ) && w_in_range;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    // Response registers; error and data-select hold until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            r_rd_sel  <= 1'b0;
        end else begin
            rsp_valid <= w_accept;
            if (w_accept) begin
                rsp_err  <= !w_in_range;
                r_rd_sel <= w_re;
            end
        end
    end

    // Writes and error responses return zero; in-range reads return the array word.
    assign read_data = r_rd_sel ? w_arr_rdata : '0;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (c_idx_w)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_wstrb (w_wstrb),
        .i_re    (w_re),
        .i_raddr (address[c_idx_w-1:0]),
        .o_rdata (w_arr_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_sync
// Description : Directed self-checking bench for dmem_sync (DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_sync;
    import dmem_pkg::*;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int AW = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   req_valid;
    logic                   req_ready;
    logic [MEM_OP_BITS-1:0] mem_op;
    logic [AW-1:0]          address;
    logic [DW-1:0]          write_data;
    logic [DW/8-1:0]        write_strb;
    logic                   rsp_valid;
    logic [DW-1:0]          read_data;
    logic                   rsp_err;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model [DP];

    always #5 clk = ~clk;

    dmem_sync #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_op     (mem_op),
        .address    (address),
        .write_data (write_data),
        .write_strb (write_strb),
        .rsp_valid  (rsp_valid),
        .read_data  (read_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request for one cycle; outputs are observable on return.
    task automatic do_req(input logic [1:0] op, input int addr, input logic [31:0] d, input logic [3:0] s);
        mem_op     = op;
        address    = AW'(addr);
        write_data = d;
        write_strb = s;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    // Watches the 16-cycle sweep after reset release.
    task automatic check_sweep(input string tag);
        for (int c = 1; c <= DP; c++) begin
            tick();
            checks++;
            if (c < DP) begin
                if (busy !== 1'b1 || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s sweep cycle %0d: busy=%b ready=%b, want busy=1 ready=0", tag, c, busy, req_ready);
                end
            end else begin
                if (busy !== 1'b0 || req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s sweep end cycle %0d: busy=%b ready=%b, want busy=0 ready=1", tag, c, busy, req_ready);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0 || read_data !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b vld=%b rd=%h err=%b, want 0 1 0 0 0",
                     req_ready, busy, rsp_valid, read_data, rsp_err);
        end
        reset = 1'b0;
        check_sweep("initial");
    endtask

    task automatic test_clear_reads(input string tag);
        for (int a = 0; a < DP; a++) begin
            do_req(MEM_OP_READ, a, 32'h0, 4'h0);
            checks++;
            if (rsp_valid !== 1'b1 || read_data !== 32'h0 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL %s zero_read addr %0d: vld=%b rd=%h err=%b, want 1 00000000 0", tag, a, rsp_valid, read_data, rsp_err);
            end
        end
    endtask

    task automatic test_write_read();
        do_req(MEM_OP_WRITE, 5, 32'hDEADBEEF, 4'hF);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL write_rsp: vld=%b err=%b rd=%h, want 1 0 00000000", rsp_valid, rsp_err, read_data);
        end
        do_req(MEM_OP_READ, 5, 32'h0, 4'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_after_write: vld=%b err=%b rd=%h, want 1 0 deadbeef", rsp_valid, rsp_err, read_data);
        end
    endtask

    task automatic test_strobe();
        do_req(MEM_OP_WRITE, 3, 32'hAAAAAAAA, 4'hF);
        do_req(MEM_OP_WRITE, 3, 32'h11223344, 4'h5);
        do_req(MEM_OP_READ, 3, 32'h0, 4'h0);
        checks++;
        if (read_data !== 32'hAA22AA44 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL strobe_merge: rd=%h err=%b, want aa22aa44 0", read_data, rsp_err);
        end
        do_req(MEM_OP_WRITE, 3, 32'h55555555, 4'h0);
        do_req(MEM_OP_READ, 3, 32'h0, 4'h0);
        checks++;
        if (read_data !== 32'hAA22AA44) begin
            errors++;
            $display("FAIL strobe_zero: rd=%h, want aa22aa44", read_data);
        end
    endtask

    task automatic test_out_of_range();
        do_req(MEM_OP_WRITE, 4, 32'h44444444, 4'hF);
        do_req(MEM_OP_WRITE, 20, 32'hFFFFFFFF, 4'hF);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL oor_write: vld=%b err=%b rd=%h, want 1 1 00000000", rsp_valid, rsp_err, read_data);
        end
        do_req(MEM_OP_READ, 20, 32'h0, 4'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: vld=%b err=%b rd=%h, want 1 1 00000000", rsp_valid, rsp_err, read_data);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: vld=%b err=%b, want 0 1", rsp_valid, rsp_err);
        end
        do_req(MEM_OP_READ, 4, 32'h0, 4'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || read_data !== 32'h44444444) begin
            errors++;
            $display("FAIL oor_alias: vld=%b err=%b rd=%h, want 1 0 44444444", rsp_valid, rsp_err, read_data);
        end
        mem_op = MEM_OP_NOP;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || read_data !== 32'h44444444) begin
            errors++;
            $display("FAIL nop_hold: vld=%b rd=%h, want 0 44444444", rsp_valid, read_data);
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int a = 0; a < DP; a++) begin
            do_req(MEM_OP_WRITE, a, 32'hC0DE0000 | 32'(a + 1), 4'hF);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 7; c++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy: busy=%b, want 1", busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_sweep_reset_state: busy=%b ready=%b vld=%b rd=%h, want 1 0 0 0", busy, req_ready, rsp_valid, read_data);
        end
        reset = 1'b0;
        check_sweep("restart");
        test_clear_reads("restart");
    endtask

    task automatic test_clear_requests();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_op     = MEM_OP_WRITE;
        address    = 8'd0;
        write_data = 32'hFFFFFFFF;
        write_strb = 4'hF;
        req_valid  = 1'b1;
        for (int c = 1; c <= DP; c++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL clear_no_rsp cycle %0d: vld=%b, want 0", c, rsp_valid);
            end
        end
        req_valid = 1'b0;
        do_req(MEM_OP_READ, 0, 32'h0, 4'h0);
        checks++;
        if (read_data !== 32'h0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_write_ignored: vld=%b rd=%h, want 1 00000000", rsp_valid, read_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        int          a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        v;
        logic        exp_vld;
        logic [31:0] exp_rd;
        logic        exp_err;
        for (int i = 0; i < DP; i++) model[i] = 32'h0;
        exp_rd  = 32'h0;
        exp_err = 1'b0;
        for (int n = 0; n < 100; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 23));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            v  = ($urandom_range(0, 3) != 0);
            exp_vld = v && (op == MEM_OP_READ || op == MEM_OP_WRITE);
            if (exp_vld) begin
                exp_err = (a >= DP);
                exp_rd  = 32'h0;
                if (!exp_err && op == MEM_OP_READ) exp_rd = model[a];
                if (!exp_err && op == MEM_OP_WRITE) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
                    end
                end
            end
            mem_op     = op;
            address    = AW'(a);
            write_data = d;
            write_strb = s;
            req_valid  = v;
            tick();
            checks++;
            if (rsp_valid !== exp_vld || read_data !== exp_rd || rsp_err !== exp_err) begin
                errors++;
                $display("FAIL b2b op %0d (op=%0d addr=%0d): vld=%b rd=%h err=%b, want %b %h %b",
                         n, op, a, rsp_valid, read_data, rsp_err, exp_vld, exp_rd, exp_err);
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        mem_op     = MEM_OP_NOP;
        address    = '0;
        write_data = '0;
        write_strb = '0;
        test_reset();
        test_clear_reads("initial");
        test_write_read();
        test_strobe();
        test_out_of_range();
        test_reset_mid_sweep();
        test_clear_requests();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_sync.md
# dmem_sync

Synchronous, parametrised data memory for the processor's MEM stage. It supports configurable width and depth, byte-lane write strobes, and a registered one-cycle read. A valid/ready request handshake and an out-of-range error response are included. After reset, a hardware clear sweep zeroes the array one word per cycle, so no combinational whole-array reset is needed.

## Interface
- `DATA_WIDTH`, default 32: word width in bits; must be a multiple of 8.
- `DEPTH`, default 1024: number of words; any value ≥ 2.
- `ADDR_WIDTH`, default 16: width of the word address; must be ≥ clog2(DEPTH).
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present this cycle.
- `req_ready` out 1: block accepts requests; low during the clear sweep.
- `mem_op` in `MEM_OP_BITS`: `MEM_OP_NOP`, `MEM_OP_READ` or `MEM_OP_WRITE`.
- `address` in `ADDR_WIDTH`: word address.
- `write_data` in `DATA_WIDTH`: write word.
- `write_strb` in `DATA_WIDTH/8`: byte-lane enables; bit i covers bits [8i+7:8i].
- `rsp_valid` out 1: response pulse, one cycle.
- `read_data` out `DATA_WIDTH`: read result, valid while `rsp_valid` is high.
- `rsp_err` out 1: address ≥ `DEPTH`; qualified by `rsp_valid`.
- `busy` out 1: clear sweep in progress.

## Operation
- The block has two states: CLEAR and RUN.
- Reset forces CLEAR and sets `clr_idx` to 0. Reset asserted mid-sweep or mid-RUN restarts the sweep from 0.
- CLEAR:
  - Each cycle writes 0 to `mem[clr_idx]` and increments `clr_idx`.
  - At `clr_idx == DEPTH-1`, the final word is written and the state moves to RUN.
  - `req_ready` = 0 and `busy` = 1 throughout. Requests are ignored and produce no response.
- RUN: `req_ready` = 1 and `busy` = 0. A request is accepted when `req_valid & req_ready` and `mem_op` ≠ `MEM_OP_NOP`.
- Write, address in range:
  - Only the lanes whose `write_strb` bit is 1 are updated; a strobe of 0 writes nothing.
  - Response: `rsp_valid` = 1, `rsp_err` = 0, `read_data` = 0.
- Read, address in range: `read_data` = `mem[address]`, `rsp_err` = 0.
- Any operation with `address` ≥ `DEPTH`:
  - The array is not modified.
  - Response: `read_data` = 0, `rsp_err` = 1.
- Read-after-write: each cycle carries a single op. A read issued the cycle after a write to the same address returns the new data.
- NOP or an unaccepted request: no response.
- Unknown `mem_op` encodings are treated as NOP.

## Timing
- Reset values, which hold in the cycle after the reset edge:
  - `req_ready` = 0, `busy` = 1
  - `rsp_valid` = 0, `read_data` = 0, `rsp_err` = 0
  - `clr_idx` = 0
- The clear sweep takes exactly `DEPTH` cycles after reset deasserts.
- The first `req_ready` = 1 occurs at cycle `DEPTH`, counting the first non-reset edge as cycle 1.
- Latency: a request accepted at edge N produces its response at edge N+1, so throughput is one op per cycle.
- `read_data` and `rsp_err` hold their values while `rsp_valid` is low. They return to 0 only on reset.
- There is no backpressure on the response side; the consumer must take every pulse.

## Structure
- Package `dmem_pkg` contains:
  - the `MEM_OP_*` encodings and `MEM_OP_BITS`, shared with the decoder and execute stage;
  - the state enum {CLEAR, RUN}.
- Sub-module `dmem_array` holds the storage: `DEPTH` × `DATA_WIDTH`, one write port with byte enables, one registered read port. It contains no reset logic.
- `dmem_sync` holds the FSM, the clear counter, range checking and response registers.

## Test plan
- Reset, then idle with `DEPTH`=16 → `busy` high for 16 cycles, `req_ready` rises on cycle 16, and reads of addresses 0–15 all return 0.
- Write 0xDEADBEEF to address 5 with strobe 0xF, then read address 5 → the read response on the next cycle returns 0xDEADBEEF with `rsp_err` = 0.
- Write 0x11223344 with strobe 0x5 onto 0xAAAAAAAA at address 3, then read → returns 0xAA22AA44.
- Write to and read from address 20 with `DEPTH`=16 → both respond with `rsp_err` = 1, `read_data` = 0. A subsequent read of address 4 (4 = 20 mod 16) returns its prior value unchanged.
- Assert reset at sweep cycle 7 after filling the array with nonzero data → the sweep restarts, `busy` stays high for 16 more cycles, and all words read 0 afterward.
- Requests during CLEAR, plus a back-to-back write/read stream of 100 random ops in RUN → no responses during CLEAR. In RUN, every response matches the reference model one cycle after acceptance.
